fadd_arbiter: RTL and testbench
===============================

# fadd_arbiter

Round-robin arbiter and sequencer that shares one `float_adder` instance between `NREQ` requesters. Accepts single-precision operand pairs over valid/ready handshakes and holds the granted operands stable on the adder inputs for the adder's fixed latency. It then captures `z` and `overflow` and returns them with the requester ID over a valid/ready response channel. The block sits between the requesting units and the adder; the adder's own clock and reset are driven from the same `clk` and `rst`.

## Interface

Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `ADD_LAT`, default 4: cycles from stable operands on `add_x`/`add_y` to valid `add_z`/`add_ovf`; must be at least 1.
- `IDW`, default 2: response ID width, equal to clog2(NREQ).

Ports:
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `req_valid` in, NREQ: per-requester request valid.
- `req_ready` out, NREQ: per-requester accept; at most one bit is high.
- `req_x` in, NREQ*32: operand x; requester i occupies bits [32i+31:32i].
- `req_y` in, NREQ*32: operand y, packed the same way.
- `add_x` out, 32: registered operand x to the adder.
- `add_y` out, 32: registered operand y to the adder.
- `add_z` in, 32: adder sum.
- `add_ovf` in, 2: adder status. 00 normal, 01 overflow, 10 underflow, 11 special (NaN/Inf/denormal).
- `rsp_valid` out, 1: response valid.
- `rsp_ready` in, 1: response accept.
- `rsp_id` out, IDW: index of the requester that owns the response.
- `rsp_z` out, 32: captured sum.
- `rsp_ovf` out, 2: captured status.
- `busy` out, 1: high whenever the state is not IDLE.

## Operation

- FSM states:
  - IDLE: `req_ready` is combinational. It selects the first i with `req_valid[i]`=1, searching from `ptr` upward with wrap at NREQ.
    - If no requester is valid, remain in IDLE.
  - On the handshake (`req_valid[g]` & `req_ready[g]`):
    - `add_x`/`add_y` latch `req_x[g]`/`req_y[g]`.
    - `rsp_id` latches g.
    - `ptr` becomes (g+1) mod NREQ.
    - `cnt` loads ADD_LAT.
    - Next state is WAIT.
  - WAIT: `cnt` decrements each cycle.
    - On the edge where `cnt`==1, `add_z` and `add_ovf` are captured into `rsp_z` and `rsp_ovf`, `rsp_valid` is set, and the next state is RESP.
  - RESP: `rsp_valid`=1, and `rsp_id`, `rsp_z` and `rsp_ovf` are held stable.
    - When `rsp_ready`=1, clear `rsp_valid` and go to IDLE.
- `req_ready` is 0 in WAIT and RESP. Only one operation is in flight at a time.
- `add_x`/`add_y` hold their last values outside WAIT. They change only on a handshake.
- The block does not interpret `add_ovf`; it forwards it unchanged.
- A requester that drops `req_valid` before it is granted is simply skipped. No state is kept for it.
- `cnt` width is clog2(ADD_LAT+1).

## Timing

- Reset values: state IDLE, `ptr`=0, `cnt`=0, `add_x`=`add_y`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_z`=0, `rsp_ovf`=0, `busy`=0.
  - `req_ready`=0 while `rst`=1.
- Handshake at cycle t:
  - `add_x`/`add_y` are valid from t+1.
  - WAIT spans cycles t+1..t+ADD_LAT.
  - `rsp_valid` is high from t+ADD_LAT+1.
- With `rsp_ready` held at 1, RESP lasts one cycle and IDLE is re-entered at t+ADD_LAT+2.
  - Minimum issue interval is therefore ADD_LAT+2 cycles.
- `rsp_ready` high in the first RESP cycle completes the response in that cycle.
- `rsp_ready` low stalls indefinitely. All response outputs stay constant and no new request is accepted.
- Simultaneous requests are granted in strict round-robin order from `ptr`. A continuously valid requester waits at most NREQ-1 grants.
- Reset in any state aborts the operation: no response is issued and the in-flight adder result is discarded.

## Test plan

- Single request: with NREQ=4, ADD_LAT=4, requester 2 sends x=3F47AE14, y=3F0CCCCD at cycle t.
  - Required: `req_ready`=0100 at t.
  - Required: `rsp_valid` rises at t+5 with `rsp_id`=2, `rsp_z`=3FAA3D70, `rsp_ovf`=00.
- All four requesters valid from reset, each with a distinct pair (0: 4248CCCC+3F8CCCCC, etc.).
  - Required: grant order 0,1,2,3.
  - Required: requester 0 returns 424D3332.
  - Required: each response ID matches its operands.
- Requester 0 held valid continuously while requester 3 asserts valid after the first grant.
  - Required: grant sequence 0,3,0,3; never two consecutive grants to 0.
- Backpressure: `rsp_ready` held at 0 for 10 cycles after `rsp_valid` rises.
  - Required: `rsp_*` stay constant, `req_ready`=0 throughout, `busy`=1.
  - Required: completion occurs in the cycle `rsp_ready` goes to 1.
- Status passthrough: x=y=7F7FFFFF.
  - Required: `rsp_z`=7FFFFFFF, `rsp_ovf`=01.
- Status passthrough: x=7F800003, y=7F800004.
  - Required: `rsp_z`=FFFFFFFF, `rsp_ovf`=11.
- Reset asserted for one cycle during WAIT (`cnt`=2).
  - Required: `rsp_valid` never rises, state is IDLE, `ptr`=0, and all outputs return to their reset values on the next cycle.

Source files
------------

// File: rtl/fadd_arbiter.sv
// rtl/fadd_arbiter.sv - round-robin arbiter/sequencer sharing one fixed-latency float adder among NREQ requesters
module fadd_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 4,
  parameter int IDW     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_x,
  input  logic [NREQ*32-1:0]   req_y,
  output logic [31:0]          add_x,
  output logic [31:0]          add_y,
  input  logic [31:0]          add_z,
  input  logic [1:0]           add_ovf,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_z,
  output logic [1:0]           rsp_ovf,
  output logic                 busy
);

  localparam int CW = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    add_x_q, add_x_d, add_y_q, add_y_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]    rsp_z_q, rsp_z_d;
  logic [1:0]     rsp_ovf_q, rsp_ovf_d;

  logic           found_hi, found_any;
  logic [IDW-1:0] idx_hi, idx_lo, gnt_idx;
  logic [31:0]    sel_x, sel_y;

  // Round-robin: lowest valid index at or above ptr wins, else lowest valid overall (wrap).
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    idx_hi    = '0;
    idx_lo    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found_any = 1'b1;
        idx_lo    = IDW'(i);
        if (IDW'(i) >= ptr_q) begin
          found_hi = 1'b1;
          idx_hi   = IDW'(i);
        end
      end
    end
    gnt_idx = found_hi ? idx_hi : idx_lo;
  end

  always_comb begin
    req_ready = '0;
    sel_x     = '0;
    sel_y     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        req_ready[i] = (state_q == S_IDLE) && !rst && found_any;
        sel_x        = req_x[i*32 +: 32];
        sel_y        = req_y[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    add_x_d     = add_x_q;
    add_y_d     = add_y_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_z_d     = rsp_z_q;
    rsp_ovf_d   = rsp_ovf_q;
    case (state_q)
      S_IDLE: begin
        if (found_any) begin
          add_x_d  = sel_x;
          add_y_d  = sel_y;
          rsp_id_d = gnt_idx;
          ptr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
          cnt_d    = CW'(ADD_LAT);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        // Last WAIT cycle: adder output is valid for the held operands.
        if (cnt_q == CW'(1)) begin
          rsp_z_d     = add_z;
          rsp_ovf_d   = add_ovf;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      add_x_q     <= '0;
      add_y_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_z_q     <= '0;
      rsp_ovf_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      add_x_q     <= add_x_d;
      add_y_q     <= add_y_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_z_q     <= rsp_z_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  assign add_x     = add_x_q;
  assign add_y     = add_y_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fadd_arbiter.sv
// tb/tb_fadd_arbiter.sv - directed-vector bench for fadd_arbiter with a table-driven fixed-latency adder model
module tb_fadd_arbiter;
  localparam int NREQ    = 4;
  localparam int ADD_LAT = 4;
  localparam int IDW     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_x, req_y;
  logic [31:0]       add_x, add_y, add_z;
  logic [1:0]        add_ovf;
  logic              rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_z;
  logic [1:0]        rsp_ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fadd_arbiter #(.NREQ(NREQ), .ADD_LAT(ADD_LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .add_x(add_x), .add_y(add_y), .add_z(add_z), .add_ovf(add_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  // Adder result is combinationally valid ADD_LAT cycles after operands settle.
  function automatic logic [33:0] add_model(input logic [31:0] x, input logic [31:0] y);
    case ({x, y})
      64'h3F47AE14_3F0CCCCD: return {2'b00, 32'h3FAA3D70};
      64'h4248CCCC_3F8CCCCC: return {2'b00, 32'h424D3332};
      64'h3F800000_3F800000: return {2'b00, 32'h40000000};
      64'h40000000_40400000: return {2'b00, 32'h40A00000};
      64'h40800000_41000000: return {2'b00, 32'h41400000};
      64'h7F7FFFFF_7F7FFFFF: return {2'b01, 32'h7FFFFFFF};
      64'h7F800003_7F800004: return {2'b11, 32'hFFFFFFFF};
      default:               return {2'b00, 32'hDEADBEEF};
    endcase
  endfunction

  logic [33:0] pipe [ADD_LAT-1];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ADD_LAT - 1; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= add_model(add_x, add_y);
      for (int i = 1; i < ADD_LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign add_z   = pipe[ADD_LAT-2][31:0];
  assign add_ovf = pipe[ADD_LAT-2][33:32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y);
    req_x[i*32 +: 32] = x;
    req_y[i*32 +: 32] = y;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // Counts cycles until rsp_valid; from the first WAIT cycle this is ADD_LAT.
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      step();
      cyc++;
    end
    if (!rsp_valid) check("rsp_timeout", 64'(rsp_valid), 64'd1);
  endtask

  task automatic run_op(input string tag, input int idx, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ez, input logic [1:0] eovf);
    int cyc;
    set_op(idx, x, y);
    req_valid = NREQ'(1) << idx;
    #1;
    check({tag, "_ready"}, 64'(req_ready), 64'(NREQ'(1) << idx));
    step();
    req_valid = '0;
    check({tag, "_operands"}, {add_x, add_y}, {x, y});
    wait_rsp(cyc);
    check({tag, "_latency"}, 64'(cyc), 64'(ADD_LAT));
    check({tag, "_rsp"}, {28'd0, rsp_id, rsp_ovf, rsp_z}, {28'd0, IDW'(idx), eovf, ez});
    step();
    check({tag, "_done"}, {62'd0, rsp_valid, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int gseq [3];
    logic seen;
    req_x = '0;
    req_y = '0;
    rsp_ready = 1'b1;

    // Reset values, and no grant while rst is high.
    rst = 1'b1;
    set_op(2, 32'h3F47AE14, 32'h3F0CCCCD);
    req_valid = 4'b0100;
    step();
    step();
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_outputs", {add_x, add_y}, 64'd0);
    check("rst_rsp", {27'd0, rsp_valid, busy, rsp_id, rsp_ovf, rsp_z}, 64'd0);

    // Single request from requester 2.
    rst = 1'b0;
    #1;
    check("single_ready", 64'(req_ready), 64'b0100);
    step();
    req_valid = '0;
    check("single_busy", {62'd0, busy, |req_ready}, 64'b10);
    check("single_operands", {add_x, add_y}, 64'h3F47AE14_3F0CCCCD);
    wait_rsp(cyc);
    check("single_latency", 64'(1 + cyc), 64'd5);
    check("single_rsp", {28'd0, rsp_id, rsp_ovf, rsp_z}, {28'd0, 2'd2, 2'b00, 32'h3FAA3D70});
    step();
    check("single_done", {62'd0, rsp_valid, busy}, 64'd0);

    // All four valid from reset: grant order 0,1,2,3.
    do_reset();
    set_op(0, 32'h4248CCCC, 32'h3F8CCCCC);
    set_op(1, 32'h3F800000, 32'h3F800000);
    set_op(2, 32'h40000000, 32'h40400000);
    set_op(3, 32'h40800000, 32'h41000000);
    req_valid = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      logic [31:0] ez;
      case (k)
        0: ez = 32'h424D3332;
        1: ez = 32'h40000000;
        2: ez = 32'h40A00000;
        default: ez = 32'h41400000;
      endcase
      #1;
      check("all_grant", 64'(req_ready), 64'(NREQ'(1) << k));
      step();
      req_valid[k] = 1'b0;
      wait_rsp(cyc);
      check("all_rsp", {30'd0, rsp_id, rsp_z}, {30'd0, IDW'(k), ez});
      step();
    end

    // Fairness: 0 held valid, 3 joins after first grant; expect 0,3,0,3.
    do_reset();
    set_op(0, 32'h3F800000, 32'h3F800000);
    set_op(3, 32'h40800000, 32'h41000000);
    req_valid = 4'b0001;
    #1;
    check("rr_first", 64'(req_ready), 64'b0001);
    step();
    req_valid = 4'b1001;
    wait_rsp(cyc);
    check("rr_first_id", 64'(rsp_id), 64'd0);
    step();
    gseq[0] = 3; gseq[1] = 0; gseq[2] = 3;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("rr_grant", 64'(req_ready), 64'(NREQ'(1) << gseq[k]));
      step();
      wait_rsp(cyc);
      check("rr_id", 64'(rsp_id), 64'(gseq[k]));
      check("rr_z", 64'(rsp_z), (gseq[k] == 3) ? 64'h41400000 : 64'h40000000);
      step();
    end
    req_valid = '0;

    // Backpressure: hold rsp_ready low 10 cycles while requester 0 waits.
    set_op(1, 32'h40000000, 32'h40400000);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    check("bp_ready", 64'(req_ready), 64'b0010);
    step();
    req_valid = 4'b0001;
    wait_rsp(cyc);
    for (int k = 0; k < 10; k++) begin
      step();
      check("bp_hold", {22'd0, rsp_valid, busy, req_ready, rsp_id, rsp_ovf, rsp_z},
            {22'd0, 1'b1, 1'b1, 4'b0000, 2'd1, 2'b00, 32'h40A00000});
    end
    rsp_ready = 1'b1;
    step();
    check("bp_complete", {62'd0, rsp_valid, busy}, 64'd0);
    check("bp_next_grant", 64'(req_ready), 64'b0001);
    req_valid = '0;
    #1;

    // Status passthrough.
    run_op("ovf", 0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7FFFFFFF, 2'b01);
    run_op("special", 2, 32'h7F800003, 32'h7F800004, 32'hFFFFFFFF, 2'b11);

    // Reset during WAIT at cnt==2 aborts the operation and clears ptr.
    set_op(1, 32'h40000000, 32'h40400000);
    req_valid = 4'b0010;
    #1;
    step();
    req_valid = '0;
    step();
    step();
    check("abort_pre", {62'd0, busy, rsp_valid}, 64'b10);
    rst = 1'b1;
    step();
    check("abort_rst_ops", {add_x, add_y}, 64'd0);
    check("abort_rst_rsp", {23'd0, rsp_valid, busy, req_ready, rsp_id, rsp_ovf, rsp_z}, 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      seen = seen | rsp_valid | busy;
    end
    check("abort_no_rsp", 64'(seen), 64'd0);
    set_op(0, 32'h3F800000, 32'h3F800000);
    req_valid = 4'b1111;
    #1;
    check("abort_ptr", 64'(req_ready), 64'b0001);
    req_valid = '0;
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
